// File: rtl/mem_request_unit_if.sv
// Bundle of the core-side and RAM-side signals of the memory request unit.
// The master modport is the sequencer's view; slave is the core/RAM environment.
interface mem_request_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] pc_addr;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_store;
    logic              mem_read;
    logic              mem_write;
    logic              halt;
    logic              ram_ready;
    logic [DATA_W-1:0] ram_load;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_store;
    logic              ram_ren;
    logic              ram_wen;
    logic [DATA_W-1:0] imemload;
    logic [DATA_W-1:0] dmemload;
    logic              i_ready;
    logic              d_ready;
    logic              pc_en;
    logic              halted;
    logic              bus_err;

    modport master (
        input  pc_addr, dmem_addr, dmem_store, mem_read, mem_write, halt,
               ram_ready, ram_load,
        output ram_addr, ram_store, ram_ren, ram_wen, imemload, dmemload,
               i_ready, d_ready, pc_en, halted, bus_err
    );

    modport slave (
        output pc_addr, dmem_addr, dmem_store, mem_read, mem_write, halt,
               ram_ready, ram_load,
        input  ram_addr, ram_store, ram_ren, ram_wen, imemload, dmemload,
               i_ready, d_ready, pc_en, halted, bus_err
    );
endinterface

// File: rtl/mem_request_unit.sv
// Multi-cycle sequencer sharing one RAM port between instruction fetch and data access.
// Optional ram_ready timeout is enabled by defining MRU_TIMEOUT_EN.
module mem_request_unit #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input logic                 clk,
    input logic                 nRST,
    mem_request_unit_if.master  bus
);

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, DATA, WB, HALT} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] imemload_q, imemload_d;
    logic [DATA_W-1:0] dmemload_q, dmemload_d;
    logic              bus_err_q, bus_err_d;
    logic              is_write_q, is_write_d;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("mem_request_unit: TIMEOUT_CYC must be at least 1");
    end

`ifdef MRU_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

    always_comb begin
        state_d    = state_q;
        imemload_d = imemload_q;
        dmemload_d = dmemload_q;
        bus_err_d  = bus_err_q;
        is_write_d = is_write_q;
`ifdef MRU_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                if (bus.ram_ready) begin
                    imemload_d = bus.ram_load;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                if (bus.halt) begin
                    state_d = HALT;
                end else if (bus.mem_write) begin
                    is_write_d = 1'b1;
                    bus_err_d  = bus_err_q | bus.mem_read;
                    state_d    = DATA;
                end else if (bus.mem_read) begin
                    is_write_d = 1'b0;
                    state_d    = DATA;
                end else begin
                    state_d = FETCH;
                end
            end
            DATA: begin
                if (bus.ram_ready) begin
                    if (!is_write_q) begin
                        dmemload_d = bus.ram_load;
                    end
                    state_d = WB;
                end
            end
            WB:      state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
`ifdef MRU_TIMEOUT_EN
        // Counter only runs while stalled; entering FETCH/DATA always follows a cycle where it was cleared.
        if ((state_q == FETCH || state_q == DATA) && !bus.ram_ready) begin
            if (wait_cnt_q == CNT_LAST) begin
                bus_err_d = 1'b1;
                state_d   = HALT;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            imemload_q <= '0;
            dmemload_q <= '0;
            bus_err_q  <= 1'b0;
            is_write_q <= 1'b0;
`ifdef MRU_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            imemload_q <= imemload_d;
            dmemload_q <= dmemload_d;
            bus_err_q  <= bus_err_d;
            is_write_q <= is_write_d;
`ifdef MRU_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    // RAM address follows the live pc/alu values so a PC advanced at the EXEC edge is fetched directly.
    assign bus.ram_ren   = (state_q == FETCH) || (state_q == DATA && !is_write_q);
    assign bus.ram_wen   = (state_q == DATA) && is_write_q;
    assign bus.ram_addr  = (state_q == FETCH) ? bus.pc_addr :
                           (state_q == DATA)  ? bus.dmem_addr : '0;
    assign bus.ram_store = (state_q == DATA && is_write_q) ? bus.dmem_store : '0;

    assign bus.imemload = imemload_q;
    assign bus.dmemload = dmemload_q;
    assign bus.i_ready  = (state_q == EXEC) || (state_q == DATA) || (state_q == WB);
    assign bus.d_ready  = (state_q == WB);
    assign bus.halted   = (state_q == HALT);
    assign bus.bus_err  = bus_err_q;

    // A non-memory instruction retires from EXEC, so its strobe depends on the control decode this cycle.
    assign bus.pc_en = (state_q == WB) ||
                       (state_q == EXEC && !bus.halt && !bus.mem_write && !bus.mem_read);

endmodule

// File: tb/tb_mem_request_unit.sv
// Self-checking bench for mem_request_unit using an instruction-level expectation model.
module tb_mem_request_unit;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int TIMEOUT_CYC = 4;

    logic clk  = 1'b0;
    logic nRST = 1'b0;

    always #5 clk = ~clk;

    mem_request_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_request_unit #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] pc_m     = 32'h0;
    logic [31:0] dmem_m   = 32'h0;
    logic        bus_err_m = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic hl,
                                 input logic rdy, input logic [31:0] load);
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.halt      = hl;
        bus.ram_ready = rdy;
        bus.ram_load  = load;
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_ren"},    32'(bus.ram_ren), 0);
        checkOutput({tag, "_wen"},    32'(bus.ram_wen), 0);
        checkOutput({tag, "_addr"},   bus.ram_addr, 0);
        checkOutput({tag, "_store"},  bus.ram_store, 0);
        checkOutput({tag, "_pc_en"},  32'(bus.pc_en), 0);
        checkOutput({tag, "_dready"}, 32'(bus.d_ready), 0);
        checkOutput({tag, "_iready"}, 32'(bus.i_ready), 0);
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #1;
        nRST      = 1'b1;
        pc_m      = 32'h0;
        dmem_m    = 32'h0;
        bus_err_m = 1'b0;
        bus.pc_addr = pc_m;
        applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
        #4;
        checkQuiet("idle");
        checkOutput("idle_halted", 32'(bus.halted), 0);
        cyc();
    endtask

    // op: 0 alu, 1 load, 2 store, 3 read+write conflict, 4 halt
    task automatic runInstr(input int op, input int wf, input int wd,
                            input logic [31:0] instr, input logic [31:0] daddr,
                            input logic [31:0] sdata, input logic [31:0] ldata,
                            input bit abort);
        bit isw;
        bus.pc_addr = pc_m;
        for (int i = 0; i <= wf; i++) begin
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), i == wf,
                          (i == wf) ? instr : $urandom);
            bus.dmem_addr  = $urandom;
            bus.dmem_store = $urandom;
            #4;
            checkOutput("fetch_ren",    32'(bus.ram_ren), 1);
            checkOutput("fetch_wen",    32'(bus.ram_wen), 0);
            checkOutput("fetch_addr",   bus.ram_addr, pc_m);
            checkOutput("fetch_store",  bus.ram_store, 0);
            checkOutput("fetch_iready", 32'(bus.i_ready), 0);
            checkOutput("fetch_pc_en",  32'(bus.pc_en), 0);
            cyc();
        end

        bus.dmem_addr  = daddr;
        bus.dmem_store = sdata;
        applyStimulus(op == 1 || op == 3, op == 2 || op == 3, op == 4, 1'($urandom), $urandom);
        #4;
        checkOutput("exec_iready",   32'(bus.i_ready), 1);
        checkOutput("exec_imemload", bus.imemload, instr);
        checkOutput("exec_pc_en",    32'(bus.pc_en), 32'(op == 0));
        checkOutput("exec_ren",      32'(bus.ram_ren), 0);
        checkOutput("exec_wen",      32'(bus.ram_wen), 0);
        checkOutput("exec_addr",     bus.ram_addr, 0);
        checkOutput("exec_bus_err",  32'(bus.bus_err), 32'(bus_err_m));
        checkOutput("exec_dmemload", bus.dmemload, dmem_m);
        cyc();
        if (op == 0) begin
            pc_m += 32'd4;
            return;
        end
        if (op == 4) return;

        isw = (op >= 2);
        if (op == 3) bus_err_m = 1'b1;
        for (int i = 0; i <= wd; i++) begin
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), (i == wd) && !abort, ldata);
            #4;
            checkOutput("data_addr",     bus.ram_addr, daddr);
            checkOutput("data_ren",      32'(bus.ram_ren), 32'(!isw));
            checkOutput("data_wen",      32'(bus.ram_wen), 32'(isw));
            checkOutput("data_store",    bus.ram_store, isw ? sdata : 32'h0);
            checkOutput("data_imemload", bus.imemload, instr);
            checkOutput("data_iready",   32'(bus.i_ready), 1);
            checkOutput("data_pc_en",    32'(bus.pc_en), 0);
            checkOutput("data_bus_err",  32'(bus.bus_err), 32'(bus_err_m));
            if (abort) begin
                #1 nRST = 1'b0;
                #1;
                checkQuiet("rst_mid_data");
                checkOutput("rst_mid_data_imemload", bus.imemload, 0);
                checkOutput("rst_mid_data_dmemload", bus.dmemload, 0);
                checkOutput("rst_mid_data_bus_err",  32'(bus.bus_err), 0);
                return;
            end
            cyc();
        end
        if (!isw) dmem_m = ldata;

        applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
        #4;
        checkOutput("wb_dready",   32'(bus.d_ready), 1);
        checkOutput("wb_pc_en",    32'(bus.pc_en), 1);
        checkOutput("wb_dmemload", bus.dmemload, dmem_m);
        checkOutput("wb_imemload", bus.imemload, instr);
        checkOutput("wb_iready",   32'(bus.i_ready), 1);
        checkOutput("wb_ren",      32'(bus.ram_ren), 0);
        checkOutput("wb_wen",      32'(bus.ram_wen), 0);
        checkOutput("wb_bus_err",  32'(bus.bus_err), 32'(bus_err_m));
        cyc();
        pc_m += 32'd4;
    endtask

    initial begin
        int r;
        int op;
        bus.pc_addr    = '0;
        bus.dmem_addr  = '0;
        bus.dmem_store = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

        #3;
        checkQuiet("reset");
        checkOutput("reset_imemload", bus.imemload, 0);
        checkOutput("reset_dmemload", bus.dmemload, 0);
        checkOutput("reset_halted",   32'(bus.halted), 0);
        checkOutput("reset_bus_err",  32'(bus.bus_err), 0);
        releaseReset();

        $display("[TB] directed instructions");
        runInstr(0, 0, 0, 32'h00500093, 32'h0,  32'h0,        32'h0,        1'b0);
        runInstr(0, 0, 0, 32'h00A00113, 32'h0,  32'h0,        32'h0,        1'b0);
        runInstr(1, 0, 0, 32'h04002183, 32'h40, 32'h0,        32'hDEADBEEF, 1'b0);
        runInstr(2, 0, 3, 32'h08F02023, 32'h80, 32'h12345678, 32'hCAFEF00D, 1'b0);
        runInstr(3, 1, 2, 32'h00000000, 32'hC0, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0);
        runInstr(0, 0, 0, 32'h00100093, 32'h0,  32'h0,        32'h0,        1'b0);

        $display("[TB] randomized instructions");
        for (int n = 0; n < 40; n++) begin
            r  = int'($urandom_range(0, 9));
            op = (r < 4) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
            runInstr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     $urandom, $urandom, $urandom, $urandom, 1'b0);
        end

        $display("[TB] halt");
        runInstr(4, 1, 0, 32'h00100073, 32'h0, 32'h0, 32'h0, 1'b0);
        for (int n = 0; n < 20; n++) begin
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
            #4;
            checkOutput("halt_halted", 32'(bus.halted), 1);
            checkQuiet("halt");
            cyc();
        end
        #1 nRST = 1'b0;
        #1;
        checkOutput("halt_rst_halted",  32'(bus.halted), 0);
        checkOutput("halt_rst_bus_err", 32'(bus.bus_err), 0);
        checkQuiet("halt_rst");
        releaseReset();

        $display("[TB] reset during data phase");
        runInstr(1, 0, 2, 32'h12345003, 32'h44, 32'h0, 32'h76543210, 1'b1);
        releaseReset();
        runInstr(0, 2, 0, 32'h00500093, 32'h0, 32'h0, 32'h0, 1'b0);
        runInstr(1, 0, 1, 32'h0FF00003, 32'h48, 32'h0, 32'h13579BDF, 1'b0);

`ifdef MRU_TIMEOUT_EN
        $display("[TB] ram_ready timeout");
        bus.pc_addr = pc_m;
        for (int n = 0; n < TIMEOUT_CYC; n++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, $urandom);
            #4;
            checkOutput("tmo_wait_ren",     32'(bus.ram_ren), 1);
            checkOutput("tmo_wait_halted",  32'(bus.halted), 0);
            checkOutput("tmo_wait_bus_err", 32'(bus.bus_err), 0);
            cyc();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, $urandom);
        #4;
        checkOutput("tmo_halted",  32'(bus.halted), 1);
        checkOutput("tmo_bus_err", 32'(bus.bus_err), 1);
        checkQuiet("tmo");
        cyc();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
